// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// counter width and the word-alignment check.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide backing store: synchronous write, asynchronous read, contents not reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] windex,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] rindex,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Store port, committed on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[windex] <= wdata;
        end
    end

    assign rdata = mem_r[rindex];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one request at a time over valid/ready,
// access after LATENCY cycles, response held until the requester takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             write_r;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic             ready_r;
    logic             valid_r;
    logic [31:0]      rdata_r;
    logic             err_r;

    logic             err_s;
    logic             access_s;
    logic             we_s;
    logic [IDX_W-1:0] index_s;
    logic [31:0]      array_rdata_s;

    // Access decode from the latched request; only meaningful on the final WAIT edge.
    always_comb begin
        index_s  = addr_r[IDX_W+1:2];
        err_s    = !is_aligned(addr_r) || (addr_r[31:2] >= 30'(DEPTH_WORDS));
        access_s = (state_r == WAIT) && (cnt_r == {CNT_W{1'b0}});
        we_s     = access_s && write_r && !err_s;
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk    (clk_i),
        .we     (we_s),
        .windex (index_s),
        .wdata  (wdata_r),
        .rindex (index_s),
        .rdata  (array_rdata_s)
    );

    // Request/response FSM with latency counter and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            write_r <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid_i && ready_r) begin
                        write_r <= req_write_i;
                        addr_r  <= req_addr_i;
                        wdata_r <= req_wdata_i;
                        cnt_r   <= CNT_W'(LATENCY - 1);
                        ready_r <= 1'b0;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        // Stores and faulting accesses report zero data.
                        err_r   <= err_s;
                        rdata_r <= (err_s || write_r) ? 32'd0 : array_rdata_s;
                        valid_r <= 1'b1;
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_r;
    assign resp_valid_o = valid_r;
    assign resp_rdata_o = rdata_r;
    assign resp_err_o   = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic checked against a word-array reference model.
module tb_dmem_responder;

    localparam int LAT   = 3;
    localparam int DEPTH = 256;

    logic        clk_i        = 1'b0;
    logic        rst_i        = 1'b0;
    logic        req_valid_i  = 1'b0;
    logic        req_write_i  = 1'b0;
    logic [31:0] req_addr_i   = 32'd0;
    logic [31:0] req_wdata_i  = 32'd0;
    logic        resp_ready_i = 1'b0;
    logic        req_ready_o;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int edge_cnt = 0;

    logic [31:0] ref_mem [DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    // Reference model: word-addressed array with alignment/range rules.
    function automatic void ref_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                       output logic [31:0] rd, output logic er);
        er = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
        rd = 32'd0;
        if (!er) begin
            if (w) ref_mem[a[9:2]] = d;
            else   rd = ref_mem[a[9:2]];
        end
    endfunction

    task automatic accept_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                              output int acc, output bit ok);
        ok = 1'b0;
        acc = 0;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_wdata_i = d;
        for (int i = 0; i < 40; i++) begin
            if (req_ready_o) begin ok = 1'b1; break; end
            @(negedge clk_i);
        end
        if (ok) begin
            @(posedge clk_i);
            #1;
            acc = edge_cnt;
        end
        req_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int edge_v, output bit ok);
        ok = 1'b0;
        edge_v = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (resp_valid_o) begin ok = 1'b1; break; end
        end
        edge_v = edge_cnt;
    endtask

    task automatic handshake();
        resp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        resp_ready_i = 1'b0;
    endtask

    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int stall,
                          output logic [31:0] rd, output logic er, output int lat, output bit ok);
        int acc, ev;
        bit ok1, ok2;
        rd = 32'd0; er = 1'b0; lat = -1;
        accept_req(w, a, d, acc, ok1);
        ok = ok1;
        if (!ok1) return;
        wait_valid(ev, ok2);
        ok = ok2;
        if (!ok2) return;
        lat = ev - acc;
        repeat (stall) @(negedge clk_i);
        rd = resp_rdata_o;
        er = resp_err_o;
        handshake();
    endtask

    task automatic test_reset();
        #12;
        chk_cnt++; if (req_ready_o !== 1'b1) $display("FAIL reset_ready: got %b exp 1", req_ready_o); else pass_cnt++;
        chk_cnt++; if (resp_valid_o !== 1'b0) $display("FAIL reset_valid: got %b exp 0", resp_valid_o); else pass_cnt++;
        chk_cnt++; if (resp_rdata_o !== 32'd0) $display("FAIL reset_rdata: got %h exp 0", resp_rdata_o); else pass_cnt++;
        chk_cnt++; if (resp_err_o !== 1'b0) $display("FAIL reset_err: got %b exp 0", resp_err_o); else pass_cnt++;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd, erd; logic er, eer; int lat; bit ok;
        ref_access(1'b1, 32'h10, 32'hDEADBEEF, erd, eer);
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, ok);
        chk_cnt++; if (!ok) $display("FAIL store_timeout: got 0 exp 1"); else pass_cnt++;
        chk_cnt++; if (lat !== LAT) $display("FAIL store_latency: got %0d exp %0d", lat, LAT); else pass_cnt++;
        chk_cnt++; if (rd !== erd || er !== eer) $display("FAIL store_resp: got %h/%b exp %h/%b", rd, er, erd, eer); else pass_cnt++;
        ref_access(1'b0, 32'h10, 32'd0, erd, eer);
        do_txn(1'b0, 32'h10, 32'd0, 0, rd, er, lat, ok);
        chk_cnt++; if (lat !== LAT) $display("FAIL load_latency: got %0d exp %0d", lat, LAT); else pass_cnt++;
        chk_cnt++; if (rd !== erd || er !== eer) $display("FAIL load_resp: got %h/%b exp %h/%b", rd, er, erd, eer); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, erd; logic er, eer; int lat; bit ok;
        ref_access(1'b0, 32'h12, 32'd0, erd, eer);
        do_txn(1'b0, 32'h12, 32'd0, 0, rd, er, lat, ok);
        chk_cnt++; if (rd !== erd || er !== eer) $display("FAIL misaligned_resp: got %h/%b exp %h/%b", rd, er, erd, eer); else pass_cnt++;
        do_txn(1'b1, 32'h13, 32'h11111111, 0, rd, er, lat, ok);
        chk_cnt++; if (er !== 1'b1) $display("FAIL misaligned_store_err: got %b exp 1", er); else pass_cnt++;
        ref_access(1'b0, 32'h10, 32'd0, erd, eer);
        do_txn(1'b0, 32'h10, 32'd0, 0, rd, er, lat, ok);
        chk_cnt++; if (rd !== erd || er !== eer) $display("FAIL misaligned_after: got %h/%b exp %h/%b", rd, er, erd, eer); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, erd; logic er, eer; int lat; bit ok;
        ref_access(1'b1, 32'h0, 32'h0BADF00D, erd, eer);
        do_txn(1'b1, 32'h0, 32'h0BADF00D, 0, rd, er, lat, ok);
        ref_access(1'b1, 32'h400, 32'h55AA55AA, erd, eer);
        do_txn(1'b1, 32'h400, 32'h55AA55AA, 0, rd, er, lat, ok);
        chk_cnt++; if (rd !== erd || er !== eer) $display("FAIL oor_store_resp: got %h/%b exp %h/%b", rd, er, erd, eer); else pass_cnt++;
        ref_access(1'b0, 32'h0, 32'd0, erd, eer);
        do_txn(1'b0, 32'h0, 32'd0, 0, rd, er, lat, ok);
        chk_cnt++; if (rd !== erd || er !== eer) $display("FAIL oor_word0: got %h/%b exp %h/%b", rd, er, erd, eer); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, erd; logic er, eer; int acc, ev, lat; bit ok;
        ref_access(1'b0, 32'h10, 32'd0, erd, eer);
        accept_req(1'b0, 32'h10, 32'd0, acc, ok);
        wait_valid(ev, ok);
        chk_cnt++; if (!ok) $display("FAIL bp_timeout: got 0 exp 1"); else pass_cnt++;
        // A store offered while stalled must be ignored.
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h10; req_wdata_i = 32'hFFFF0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk_cnt++;
            if (resp_valid_o !== 1'b1 || resp_rdata_o !== erd || req_ready_o !== 1'b0)
                $display("FAIL bp_hold: got v=%b d=%h r=%b exp v=1 d=%h r=0", resp_valid_o, resp_rdata_o, req_ready_o, erd);
            else pass_cnt++;
        end
        req_valid_i = 1'b0;
        handshake();
        @(negedge clk_i);
        chk_cnt++; if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) $display("FAIL bp_release: got v=%b r=%b exp v=0 r=1", resp_valid_o, req_ready_o); else pass_cnt++;
        ref_access(1'b0, 32'h10, 32'd0, erd, eer);
        do_txn(1'b0, 32'h10, 32'd0, 0, rd, er, lat, ok);
        chk_cnt++; if (rd !== erd) $display("FAIL bp_ignored_store: got %h exp %h", rd, erd); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int acc_q[$];
        logic [31:0] erd; logic eer;
        ref_access(1'b0, 32'h10, 32'd0, erd, eer);
        @(negedge clk_i);
        resp_ready_i = 1'b1;
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h10;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk_i);
            if (i == 31) req_valid_i = 1'b0;
            if (req_valid_i && req_ready_o) acc_q.push_back(edge_cnt + 1);
            if (resp_valid_o) begin
                chk_cnt++; if (resp_rdata_o !== erd) $display("FAIL b2b_rdata: got %h exp %h", resp_rdata_o, erd); else pass_cnt++;
            end
        end
        for (int i = 0; i < 20; i++) begin
            if (req_ready_o && !resp_valid_o) break;
            @(negedge clk_i);
        end
        resp_ready_i = 1'b0;
        chk_cnt++; if (acc_q.size() < 5) $display("FAIL b2b_count: got %0d exp >=5", acc_q.size()); else pass_cnt++;
        for (int k = 1; k < acc_q.size(); k++) begin
            chk_cnt++;
            if (acc_q[k] - acc_q[k-1] !== LAT + 2) $display("FAIL b2b_spacing: got %0d exp %0d", acc_q[k] - acc_q[k-1], LAT + 2);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; logic er, eer; int acc, lat; bit ok;
        ref_access(1'b1, 32'h20, 32'hCAFEF00D, erd, eer);
        do_txn(1'b1, 32'h20, 32'hCAFEF00D, 0, rd, er, lat, ok);
        do_txn(1'b0, 32'h10, 32'd0, 0, rd, er, lat, ok);
        accept_req(1'b1, 32'h20, 32'h12345678, acc, ok);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        chk_cnt++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_rdata_o !== 32'd0 || resp_err_o !== 1'b0)
            $display("FAIL midreset_outputs: got r=%b v=%b d=%h e=%b exp r=1 v=0 d=0 e=0", req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o);
        else pass_cnt++;
        @(negedge clk_i);
        rst_i = 1'b1;
        ref_access(1'b0, 32'h20, 32'd0, erd, eer);
        do_txn(1'b0, 32'h20, 32'd0, 0, rd, er, lat, ok);
        chk_cnt++; if (rd !== erd || er !== eer) $display("FAIL midreset_dropped_store: got %h/%b exp %h/%b", rd, er, erd, eer); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, d; logic er, eer, w; int lat, kind; bit ok;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            a = 32'(i * 4);
            ref_access(1'b1, a, d, erd, eer);
            do_txn(1'b1, a, d, 0, rd, er, lat, ok);
        end
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 7);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (kind < 6)       a = 32'($urandom_range(0, 15) * 4);
            else if (kind == 6) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else                a = 32'(($urandom_range(0, 1023) + DEPTH) * 4);
            ref_access(w, a, d, erd, eer);
            do_txn(w, a, d, $urandom_range(0, 3), rd, er, lat, ok);
            chk_cnt++;
            if (!ok || lat !== LAT || rd !== erd || er !== eer)
                $display("FAIL rand_txn: addr=%h w=%b got %h/%b lat=%0d exp %h/%b lat=%0d", a, w, rd, er, lat, erd, eer, LAT);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
